// File: rtl/frame_pass_sequencer.sv
// frame_pass_sequencer: copies one frame from bank 0 to bank 1 over a shared req/gnt port, with optional invert and H/V mirror
module frame_pass_sequencer #(
  parameter int ROWS   = 240,
  parameter int COLS   = 320,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        mode_i,
  input  logic              gnt_i,
  input  logic [DATA_W-1:0] rdData_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              memReq_o,
  output logic              memRD_o,
  output logic              memWR_o,
  output logic [7:0]        addr0_o,
  output logic [8:0]        addr1_o,
  output logic [DATA_W-1:0] wrData_o
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;
  localparam logic [7:0] ROW_MAX  = 8'(ROWS - 1);
  localparam logic [8:0] COL_MAX  = 9'(COLS - 1);
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);
  state_e            state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [8:0]        col_q, col_d;
  logic [2:0]        mode_q, mode_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_col, last_row;
  assign last_col = col_q == COL_MAX;
  assign last_row = row_q == ROW_MAX;
  // state register; reset abandons any pass in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: each memory access waits for its grant, reads wait out the fixed latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? RD_REQ : IDLE;
      RD_REQ:  state_d = gnt_i ? RD_WAIT : RD_REQ;
      RD_WAIT: state_d = (lat_q == '0) ? WR_REQ : RD_WAIT;
      WR_REQ:  state_d = !gnt_i ? WR_REQ : (last_col && last_row) ? DONE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end
  // datapath next values: pixel counters, latched mode, latency count, captured pixel, status flags
  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    mode_d    = mode_q;
    lat_d     = lat_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      IDLE: if (start_i) begin
        row_d  = '0;
        col_d  = '0;
        mode_d = mode_i;
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      RD_REQ: if (gnt_i) lat_d = LAT_INIT;
      RD_WAIT: begin
        lat_d     = (lat_q == '0) ? lat_q : lat_q - 3'd1;
        wr_data_d = (lat_q != '0) ? wr_data_q : mode_q[0] ? ~rdData_i : rdData_i;
      end
      WR_REQ: if (gnt_i) begin
        col_d  = last_col ? (last_row ? col_q : '0) : col_q + 9'd1;
        row_d  = (last_col && !last_row) ? row_q + 8'd1 : row_q;
        busy_d = !(last_col && last_row);
        done_d = last_col && last_row;
      end
      default: ;
    endcase
  end
  // datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q     <= '0;
      col_q     <= '0;
      mode_q    <= '0;
      lat_q     <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      mode_q    <= mode_d;
      lat_q     <= lat_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  // outputs: port signals only live in the request states, writes use the mirrored address
  always_comb begin
    memReq_o = (state_q == RD_REQ) || (state_q == WR_REQ);
    memRD_o  = state_q == RD_REQ;
    memWR_o  = state_q == WR_REQ;
    addr0_o  = memRD_o ? row_q : memWR_o ? (mode_q[2] ? ROW_MAX - row_q : row_q) : '0;
    addr1_o  = memRD_o ? col_q : memWR_o ? (mode_q[1] ? COL_MAX - col_q : col_q) : '0;
    wrData_o = memWR_o ? wr_data_q : '0;
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_frame_pass_sequencer.sv
// tb_frame_pass_sequencer: directed checks of the frame pass sequencer on three sizings
module tb_frame_pass_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic        start_a = 1'b0, gnt_a = 1'b0, start_b = 1'b0, gnt_b = 1'b0, start_c = 1'b0, gnt_c = 1'b0;
  logic [2:0]  mode_a = '0, mode_b = '0, mode_c = '0;
  logic [31:0] rd_a = '0, rd_b = '0, rd_c = '0;
  logic        busy_a, done_a, req_a, rdst_a, wrst_a;
  logic        busy_b, done_b, req_b, rdst_b, wrst_b;
  logic        busy_c, done_c, req_c, rdst_c, wrst_c;
  logic [7:0]  a0_a, a0_b, a0_c;
  logic [8:0]  a1_a, a1_b, a1_c;
  logic [31:0] wd_a, wd_b, wd_c;

  frame_pass_sequencer #(.ROWS(2), .COLS(3), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .mode_i(mode_a), .gnt_i(gnt_a), .rdData_i(rd_a),
    .busy_o(busy_a), .done_o(done_a), .memReq_o(req_a), .memRD_o(rdst_a), .memWR_o(wrst_a),
    .addr0_o(a0_a), .addr1_o(a1_a), .wrData_o(wd_a));
  frame_pass_sequencer dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .mode_i(mode_b), .gnt_i(gnt_b), .rdData_i(rd_b),
    .busy_o(busy_b), .done_o(done_b), .memReq_o(req_b), .memRD_o(rdst_b), .memWR_o(wrst_b),
    .addr0_o(a0_b), .addr1_o(a1_b), .wrData_o(wd_b));
  frame_pass_sequencer #(.ROWS(2), .COLS(3), .DATA_W(32), .RD_LAT(3)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .mode_i(mode_c), .gnt_i(gnt_c), .rdData_i(rd_c),
    .busy_o(busy_c), .done_o(done_c), .memReq_o(req_c), .memRD_o(rdst_c), .memWR_o(wrst_c),
    .addr0_o(a0_c), .addr1_o(a1_c), .wrData_o(wd_c));

  task test_reset;
    #12;
    n_chk++; if ({busy_a, done_a, req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a} !== 54'd0) begin n_fail++; $display("FAIL reset_a: outputs=%h required 0", {busy_a, done_a, req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a}); end
    n_chk++; if ({busy_b, done_b, req_b, rdst_b, wrst_b, a0_b, a1_b, wd_b} !== 54'd0) begin n_fail++; $display("FAIL reset_b: outputs=%h required 0", {busy_b, done_b, req_b, rdst_b, wrst_b, a0_b, a1_b, wd_b}); end
    n_chk++; if ({busy_c, done_c, req_c, rdst_c, wrst_c, a0_c, a1_c, wd_c} !== 54'd0) begin n_fail++; $display("FAIL reset_c: outputs=%h required 0", {busy_c, done_c, req_c, rdst_c, wrst_c, a0_c, a1_c, wd_c}); end
    @(negedge clk); rst_n = 1'b1; gnt_a = 1'b1; rd_a = 32'h5555AAAA;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midpass_busy: busy=%b required 1", busy_a); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy_a, done_a, req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a} !== 54'd0) begin n_fail++; $display("FAIL async_reset: outputs=%h required 0", {busy_a, done_a, req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a}); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if ({busy_a, done_a, req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a} !== 54'd0) begin n_fail++; $display("FAIL post_reset_idle: cycle %0d outputs=%h required 0", i, {busy_a, done_a, req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a}); end
    end
    gnt_a = 1'b0;
  endtask

  task test_pass;
    int pix, cyc;
    pix = 0; cyc = 0; mode_a = 3'b000; gnt_a = 1'b1; rd_a = 32'hA5000000;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n_chk++; if ({busy_a, done_a} !== 2'b10) begin n_fail++; $display("FAIL pass_start: busy,done=%b required 10", {busy_a, done_a}); end
    while (done_a !== 1'b1 && cyc < 60) begin
      n_chk++; if (rdst_a && wrst_a) begin n_fail++; $display("FAIL pass_strobes: rd and wr both high at cycle %0d", cyc); end
      if (wrst_a) begin
        n_chk++; if ({a0_a, a1_a, wd_a} !== {8'(pix / 3), 9'(pix % 3), 32'hA5000000 + pix}) begin n_fail++; $display("FAIL pass_write%0d: row=%0d col=%0d data=%h required row=%0d col=%0d data=%h", pix, a0_a, a1_a, wd_a, pix / 3, pix % 3, 32'hA5000000 + pix); end
        pix++; rd_a = 32'hA5000000 + pix;
      end
      @(negedge clk); cyc++;
    end
    n_chk++; if (cyc !== 18) begin n_fail++; $display("FAIL pass_done_cycle: done after %0d cycles required 18", cyc); end
    n_chk++; if (pix !== 6) begin n_fail++; $display("FAIL pass_writes: %0d writes required 6", pix); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL pass_busy_fall: busy=%b required 0 with done", busy_a); end
    @(negedge clk);
    n_chk++; if ({busy_a, done_a, req_a} !== 3'b010) begin n_fail++; $display("FAIL pass_idle: busy,done,req=%b required 010", {busy_a, done_a, req_a}); end
  endtask

  task test_invert;
    logic [31:0] din [6];
    logic [31:0] dexp [6];
    int pix, cyc;
    din  = '{32'h00FF00FF, 32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'h80000001, 32'hA5A5A5A5};
    dexp = '{32'hFF00FF00, 32'h00000000, 32'hFFFFFFFF, 32'hEDCBA987, 32'h7FFFFFFE, 32'h5A5A5A5A};
    pix = 0; cyc = 0; mode_a = 3'b001; gnt_a = 1'b1; rd_a = din[0];
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL invert_done_clear: done=%b required 0", done_a); end
    while (done_a !== 1'b1 && cyc < 60) begin
      if (wrst_a) begin
        n_chk++; if ({a0_a, a1_a, wd_a} !== {8'(pix / 3), 9'(pix % 3), dexp[pix]}) begin n_fail++; $display("FAIL invert_write%0d: row=%0d col=%0d data=%h required row=%0d col=%0d data=%h", pix, a0_a, a1_a, wd_a, pix / 3, pix % 3, dexp[pix]); end
        pix++; rd_a = (pix < 6) ? din[pix] : 32'h0;
      end
      @(negedge clk); cyc++;
    end
    n_chk++; if (pix !== 6) begin n_fail++; $display("FAIL invert_writes: %0d writes required 6", pix); end
    mode_a = 3'b000;
  endtask

  task test_stall;
    int cyc;
    mode_a = 3'b000; gnt_a = 1'b0; rd_a = 32'h13579BDF;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if ({req_a, rdst_a, wrst_a, a0_a, a1_a} !== {3'b110, 8'd0, 9'd0}) begin n_fail++; $display("FAIL stall_rd%0d: req,rd,wr=%b row=%0d col=%0d required 110 row=0 col=0", i, {req_a, rdst_a, wrst_a}, a0_a, a1_a); end
      if (i == 1) begin start_a = 1'b1; mode_a = 3'b111; end
      if (i == 2) start_a = 1'b0;
      @(negedge clk);
    end
    gnt_a = 1'b1;
    @(negedge clk); gnt_a = 1'b0;
    n_chk++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL stall_wait_req: req=%b required 0", req_a); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if ({req_a, rdst_a, wrst_a, a0_a, a1_a, wd_a} !== {3'b101, 8'd0, 9'd0, 32'h13579BDF}) begin n_fail++; $display("FAIL stall_wr%0d: req,rd,wr=%b row=%0d col=%0d data=%h required 101 row=0 col=0 data=13579bdf", i, {req_a, rdst_a, wrst_a}, a0_a, a1_a, wd_a); end
      if (i == 0) rd_a = 32'hFFFF0000;
      @(negedge clk);
    end
    gnt_a = 1'b1;
    @(negedge clk);
    n_chk++; if ({req_a, rdst_a, a0_a, a1_a} !== {2'b11, 8'd0, 9'd1}) begin n_fail++; $display("FAIL stall_advance: req,rd=%b row=%0d col=%0d required 11 row=0 col=1", {req_a, rdst_a}, a0_a, a1_a); end
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    n_chk++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL stall_finish: done=%b required 1 within 50 cycles", done_a); end
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n_chk++; if ({busy_a, done_a, req_a} !== 3'b010) begin n_fail++; $display("FAIL start_in_done: busy,done,req=%b required 010", {busy_a, done_a, req_a}); end
    @(negedge clk);
    n_chk++; if ({busy_a, req_a} !== 2'b00) begin n_fail++; $display("FAIL start_in_done_idle: busy,req=%b required 00", {busy_a, req_a}); end
    mode_a = 3'b000;
  endtask

  task test_mirror;
    int rp, wp, cyc;
    rp = 0; wp = 0; cyc = 0; mode_b = 3'b110; gnt_b = 1'b1; rd_b = 32'h00B00000;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    while (rp <= 320 && cyc < 1200) begin
      if (rdst_b) begin
        n_chk++; if ({a0_b, a1_b} !== {8'(rp / 320), 9'(rp % 320)}) begin n_fail++; $display("FAIL mirror_read%0d: row=%0d col=%0d required row=%0d col=%0d", rp, a0_b, a1_b, rp / 320, rp % 320); end
        rp++;
      end
      if (wrst_b) begin
        n_chk++; if ({a0_b, a1_b, wd_b} !== {8'(239 - wp / 320), 9'(319 - wp % 320), 32'h00B00000 + wp}) begin n_fail++; $display("FAIL mirror_write%0d: row=%0d col=%0d data=%h required row=%0d col=%0d data=%h", wp, a0_b, a1_b, wd_b, 239 - wp / 320, 319 - wp % 320, 32'h00B00000 + wp); end
        wp++; rd_b = 32'h00B00000 + wp;
      end
      @(negedge clk); cyc++;
    end
    n_chk++; if (rp !== 321 || wp !== 320) begin n_fail++; $display("FAIL mirror_progress: reads=%0d writes=%0d required 321 and 320", rp, wp); end
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; gnt_b = 1'b0;
    @(negedge clk);
    n_chk++; if ({busy_b, req_b} !== 2'b00) begin n_fail++; $display("FAIL mirror_abandon: busy,req=%b required 00", {busy_b, req_b}); end
  endtask

  task test_latency;
    int pix, cyc, since;
    pix = 0; cyc = 0; since = -1; mode_c = 3'b000; gnt_c = 1'b1; rd_c = 32'hBAD00000;
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    while (done_c !== 1'b1 && cyc < 100) begin
      if (since >= 0) since++;
      if (rdst_c) since = 0;
      if (since >= 1 && since <= 3) begin
        n_chk++; if (req_c !== 1'b0) begin n_fail++; $display("FAIL lat_wait_req: req=%b required 0 at wait cycle %0d", req_c, since); end
      end
      if (wrst_c) begin
        n_chk++; if ({a0_c, a1_c, wd_c} !== {8'(pix / 3), 9'(pix % 3), 32'hC0DE0000 + pix} || since !== 4) begin n_fail++; $display("FAIL lat_write%0d: row=%0d col=%0d data=%h gap=%0d required row=%0d col=%0d data=%h gap=4", pix, a0_c, a1_c, wd_c, since, pix / 3, pix % 3, 32'hC0DE0000 + pix); end
        pix++; since = -1;
      end
      rd_c = (since == 3) ? 32'hC0DE0000 + pix : 32'hBAD00000;
      @(negedge clk); cyc++;
    end
    n_chk++; if (cyc !== 30 || pix !== 6) begin n_fail++; $display("FAIL lat_done: done after %0d cycles with %0d writes required 30 and 6", cyc, pix); end
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    n_chk++; if ({done_c, busy_c, rdst_c, a0_c, a1_c} !== {3'b011, 8'd0, 9'd0}) begin n_fail++; $display("FAIL lat_restart: done,busy,rd=%b row=%0d col=%0d required 011 row=0 col=0", {done_c, busy_c, rdst_c}, a0_c, a1_c); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_pass;
    test_invert;
    test_stall;
    test_mirror;
    test_latency;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
